// File: rtl/io_port_responder.sv
// ---------------------------------------------------------------------------
// io_port_responder
//   Memory-mapped I/O responder for the core's load/store bus. It decodes a
//   32-byte window at BASE_ADDR, owns the PortOut register and samples the
//   asynchronous PortIn through a synchronizer with change detection.
//   With IO_PORT_TIMER_EN defined, a periodic down-counting timer is added.
//
//   Register map (word offset = Address[4:2], Address[1:0] ignored):
//     0x00 PORT_OUT    RW   drives PortOut
//     0x04 PORT_IN     RO   zero-extended synchronized PortIn
//     0x08 STATUS      RW1C bit0 CHG, bit1 TEXP
//     0x0C TIMER_LOAD  RW   (IO_PORT_TIMER_EN only, else reads 0)
//     0x10 TIMER_COUNT RO   (IO_PORT_TIMER_EN only, else reads 0)
//     0x14-0x1C        reads 0, writes ignored
//
//   Ports:
//     clk       system clock, rising edge
//     reset     asynchronous, active-low reset
//     Address   byte address from the core
//     WriteData store data
//     MemWrite  store strobe
//     MemRead   load strobe
//     ReadData  load data, 0 unless MemRead && Hit (combinational)
//     Hit       Address falls inside the window (combinational)
//     PortIn    asynchronous external input
//     PortOut   PORT_OUT register
//     Irq       registered level of CHG | TEXP
// ---------------------------------------------------------------------------
module io_port_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h1001_0100,
   parameter int          IN_WIDTH    = 8,
   parameter int          SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [31:0]         Address,
   input  logic [31:0]         WriteData,
   input  logic                MemWrite,
   input  logic                MemRead,
   output logic [31:0]         ReadData,
   output logic                Hit,
   input  logic [IN_WIDTH-1:0] PortIn,
   output logic [31:0]         PortOut,
   output logic                Irq
);

   // Warm-up spans SYNC_STAGES+1 edges: the chain must fill and prev must
   // catch up once before a sync/prev difference means a real input change.
   localparam int WARM_MAX = SYNC_STAGES + 1;
   localparam int WARM_W   = $clog2(WARM_MAX + 1);

   logic [2:0]  offset;
   logic        wr_en;
   logic        clr_chg;
   logic        chg_set;
   logic        warm_done;
   logic        texp_flag;
   logic        unused_addr;

   logic [31:0]                         port_out_q, port_out_d;
   logic [SYNC_STAGES-1:0][IN_WIDTH-1:0] sync_q;
   logic [IN_WIDTH-1:0]                 sync_val;
   logic [IN_WIDTH-1:0]                 prev_q;
   logic [WARM_W-1:0]                   warm_q, warm_d;
   logic                                chg_q, chg_d;
   logic                                irq_q;
   logic [31:0]                         port_in_word;

   assign unused_addr = ^Address[1:0];

   assign Hit     = (Address[31:5] == BASE_ADDR[31:5]);
   assign offset  = Address[4:2];
   assign wr_en   = MemWrite && Hit;
   assign clr_chg = wr_en && (offset == 3'd2) && WriteData[0];

   assign sync_val  = sync_q[SYNC_STAGES-1];
   assign warm_done = (warm_q == WARM_W'(WARM_MAX));
   assign chg_set   = warm_done && (sync_val != prev_q);

   always_comb begin
      port_out_d = port_out_q;
      if (wr_en && (offset == 3'd0)) begin
         port_out_d = WriteData;
      end
      warm_d = warm_done ? warm_q : warm_q + 1'b1;
      // A new change outranks a simultaneous W1C so no event is lost.
      chg_d  = chg_set | (chg_q & ~clr_chg);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         port_out_q <= '0;
         sync_q     <= '0;
         prev_q     <= '0;
         warm_q     <= '0;
         chg_q      <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         port_out_q <= port_out_d;
         sync_q     <= {sync_q[SYNC_STAGES-2:0], PortIn};
         prev_q     <= sync_val;
         warm_q     <= warm_d;
         chg_q      <= chg_d;
         irq_q      <= chg_q | texp_flag;
      end
   end

`ifdef IO_PORT_TIMER_EN
   logic [31:0] load_q, load_d;
   logic [31:0] count_q, count_d;
   logic        texp_q, texp_d;
   logic        texp_set;
   logic        clr_texp;

   assign clr_texp  = wr_en && (offset == 3'd2) && WriteData[1];
   assign texp_flag = texp_q;

   always_comb begin
      load_d   = load_q;
      count_d  = count_q;
      texp_set = 1'b0;
      // A TIMER_LOAD write restarts the period and overrides any expiry.
      if (wr_en && (offset == 3'd3)) begin
         load_d  = WriteData;
         count_d = WriteData;
      end else if (count_q != 32'd0) begin
         if (count_q == 32'd1) begin
            texp_set = 1'b1;
            count_d  = load_q;
         end else begin
            count_d = count_q - 32'd1;
         end
      end
      texp_d = texp_set | (texp_q & ~clr_texp);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         load_q  <= '0;
         count_q <= '0;
         texp_q  <= 1'b0;
      end else begin
         load_q  <= load_d;
         count_q <= count_d;
         texp_q  <= texp_d;
      end
   end
`else
   assign texp_flag = 1'b0;
`endif

   always_comb begin
      port_in_word                 = '0;
      port_in_word[IN_WIDTH-1:0]   = sync_val;
   end

   // Reads come straight from current state, so a combined read+write
   // returns the value held before the write edge.
   always_comb begin
      ReadData = '0;
      if (MemRead && Hit) begin
         case (offset)
            3'd0:    ReadData = port_out_q;
            3'd1:    ReadData = port_in_word;
            3'd2:    ReadData = {30'd0, texp_flag, chg_q};
`ifdef IO_PORT_TIMER_EN
            3'd3:    ReadData = load_q;
            3'd4:    ReadData = count_q;
`endif
            default: ReadData = '0;
         endcase
      end
   end

   assign PortOut = port_out_q;
   assign Irq     = irq_q;

endmodule

// File: tb/tb_io_port_responder.sv
// ---------------------------------------------------------------------------
// tb_io_port_responder
//   Directed bench for io_port_responder: reset, PORT_OUT, decode, input
//   synchronizer / CHG / Irq, same-cycle conflicts, timer (either build),
//   asynchronous reset mid-run and post-reset warm-up.
// ---------------------------------------------------------------------------
module tb_io_port_responder;

   localparam logic [31:0] BASE = 32'h1001_0100;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] ReadData;
   logic        Hit;
   logic [7:0]  PortIn;
   logic [31:0] PortOut;
   logic        Irq;

   int total = 0;
   int bad   = 0;
   logic [31:0] rv;

   io_port_responder #(
      .BASE_ADDR   (BASE),
      .IN_WIDTH    (8),
      .SYNC_STAGES (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .Address   (Address),
      .WriteData (WriteData),
      .MemWrite  (MemWrite),
      .MemRead   (MemRead),
      .ReadData  (ReadData),
      .Hit       (Hit),
      .PortIn    (PortIn),
      .PortOut   (PortOut),
      .Irq       (Irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %-18s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      Address   = a;
      WriteData = d;
      MemWrite  = 1'b1;
      MemRead   = 1'b0;
      tick();
      MemWrite  = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      Address = a;
      MemRead = 1'b1;
      #1;
      d       = ReadData;
      MemRead = 1'b0;
   endtask

   initial begin
      reset = 1'b0; Address = '0; WriteData = '0;
      MemWrite = 1'b0; MemRead = 1'b0; PortIn = 8'h00;

      // Reset state
      tick(); tick();
      chk("rst_portout", PortOut, 32'h0);
      chk("rst_irq", {31'd0, Irq}, 32'h0);
      rd(BASE + 32'h08, rv); chk("rst_status", rv, 32'h0);
      reset = 1'b1;
      repeat (4) tick();

      // PORT_OUT write and low-address-bit decode
      wr(BASE + 32'h00, 32'hDEAD_BEEF);
      chk("portout_write", PortOut, 32'hDEAD_BEEF);
      rd(BASE + 32'h03, rv); chk("rd_base_plus3", rv, 32'hDEAD_BEEF);

      // Decode: outside window, unmapped offsets
      wr(BASE + 32'h20, 32'h1234_5678);
      chk("miss_no_write", PortOut, 32'hDEAD_BEEF);
      Address = BASE + 32'h20; MemRead = 1'b1; #1;
      chk("miss_hit", {31'd0, Hit}, 32'h0);
      chk("miss_rdata", ReadData, 32'h0);
      MemRead = 1'b0;
      Address = BASE + 32'h1C; #1;
      chk("edge_hit", {31'd0, Hit}, 32'h1);
      wr(BASE + 32'h14, 32'hFFFF_FFFF);
      rd(BASE + 32'h14, rv); chk("rd_unmapped14", rv, 32'h0);
      chk("unmapped_nowr", PortOut, 32'hDEAD_BEEF);

      // Input path: visible after 2 edges, CHG one edge later, Irq one more
      PortIn = 8'hA5;
      tick();
      rd(BASE + 32'h04, rv); chk("portin_1edge", rv, 32'h0);
      tick();
      rd(BASE + 32'h04, rv); chk("portin_2edge", rv, 32'hA5);
      rd(BASE + 32'h08, rv); chk("chg_not_yet", rv, 32'h0);
      tick();
      rd(BASE + 32'h08, rv); chk("chg_set", rv, 32'h1);
      chk("irq_lag", {31'd0, Irq}, 32'h0);
      tick();
      chk("irq_set", {31'd0, Irq}, 32'h1);
      wr(BASE + 32'h08, 32'h1);
      rd(BASE + 32'h08, rv); chk("chg_w1c", rv, 32'h0);
      tick();
      chk("irq_clear", {31'd0, Irq}, 32'h0);

      // CHG set and W1C on the same edge: set wins
      PortIn = 8'h5A;
      tick(); tick();
      wr(BASE + 32'h08, 32'h1);
      rd(BASE + 32'h08, rv); chk("chg_set_wins", rv, 32'h1);
      wr(BASE + 32'h08, 32'h1);
      rd(BASE + 32'h08, rv); chk("chg_w1c_again", rv, 32'h0);

      // Read and write together: pre-write value, then new value
      wr(BASE + 32'h00, 32'h5);
      Address = BASE; WriteData = 32'h9; MemWrite = 1'b1; MemRead = 1'b1; #1;
      chk("rmw_old", ReadData, 32'h5);
      tick();
      MemWrite = 1'b0; #1;
      chk("rmw_new", ReadData, 32'h9);
      MemRead = 1'b0;
      chk("rmw_portout", PortOut, 32'h9);

`ifdef IO_PORT_TIMER_EN
      // Timer: load 3 -> count 3,2,1,3,... TEXP at the 3rd edge
      wr(BASE + 32'h0C, 32'd3);
      rd(BASE + 32'h10, rv); chk("tmr_cnt3", rv, 32'd3);
      tick();
      rd(BASE + 32'h10, rv); chk("tmr_cnt2", rv, 32'd2);
      tick();
      rd(BASE + 32'h10, rv); chk("tmr_cnt1", rv, 32'd1);
      rd(BASE + 32'h08, rv); chk("tmr_no_texp", rv, 32'h0);
      tick();
      rd(BASE + 32'h10, rv); chk("tmr_reload", rv, 32'd3);
      rd(BASE + 32'h08, rv); chk("tmr_texp", rv, 32'h2);
      rd(BASE + 32'h0C, rv); chk("tmr_load_rd", rv, 32'd3);
      tick();
      chk("tmr_irq", {31'd0, Irq}, 32'h1);
      wr(BASE + 32'h08, 32'h2);
      rd(BASE + 32'h08, rv); chk("tmr_w1c", rv, 32'h0);
      rd(BASE + 32'h10, rv); chk("tmr_cnt1b", rv, 32'd1);
      tick();
      rd(BASE + 32'h08, rv); chk("tmr_texp2", rv, 32'h2);
      wr(BASE + 32'h08, 32'h2);
      wr(BASE + 32'h0C, 32'd0);
      repeat (3) tick();
      rd(BASE + 32'h10, rv); chk("tmr_stopped", rv, 32'd0);
      rd(BASE + 32'h08, rv); chk("tmr_stop_st", rv, 32'h0);
      wr(BASE + 32'h0C, 32'd5);
`else
      // Timer absent: offsets read 0 and TEXP never sets
      wr(BASE + 32'h0C, 32'd3);
      rd(BASE + 32'h0C, rv); chk("notmr_load", rv, 32'h0);
      rd(BASE + 32'h10, rv); chk("notmr_count", rv, 32'h0);
      repeat (5) tick();
      rd(BASE + 32'h08, rv); chk("notmr_status", rv, 32'h0);
      chk("notmr_irq", {31'd0, Irq}, 32'h0);
`endif

      // Raise Irq, then assert reset between edges: immediate clear
      PortIn = 8'h3C;
      repeat (4) tick();
      chk("pre_rst_irq", {31'd0, Irq}, 32'h1);
      reset = 1'b0; #2;
      chk("async_portout", PortOut, 32'h0);
      chk("async_irq", {31'd0, Irq}, 32'h0);
      rd(BASE + 32'h08, rv); chk("async_status", rv, 32'h0);
`ifdef IO_PORT_TIMER_EN
      rd(BASE + 32'h10, rv); chk("async_count", rv, 32'h0);
`endif

      // Warm-up: PortIn held at 0xFF across reset must not raise CHG
      PortIn = 8'hFF;
      tick();
      reset = 1'b1;
      repeat (6) tick();
      rd(BASE + 32'h08, rv); chk("warm_no_chg", rv, 32'h0);
      chk("warm_no_irq", {31'd0, Irq}, 32'h0);
      rd(BASE + 32'h04, rv); chk("warm_portin", rv, 32'hFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
